// File: rtl/router_stress_pkg.sv
// Shared definitions for the router stress/soak blocks:
// header field positions, LFSR polynomial, eject FSM states.
package router_stress_pkg;

   localparam int DEST_ROW_MSB = 15;
   localparam int DEST_ROW_LSB = 8;
   localparam int DEST_COL_MSB = 7;
   localparam int DEST_COL_LSB = 0;

   localparam logic [15:0] LFSR_POLY = 16'hB400;

   typedef enum logic {
      ACCEPT = 1'b0,
      HOLD   = 1'b1
   } eject_state_e;

   // Right-shifting Galois step; feedback taps come from LFSR_POLY.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/eject_fifo.sv
// Synchronous FIFO for ejected flits; head shows zero when empty.
// Ports: clk, rst_n, push/din, pop/dout, full, empty, occ.
module eject_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int OW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [OW-1:0]    occ
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (occ == OW'(DEPTH));
   assign empty   = (occ == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage needs no reset: dout is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/router_local_eject_sink.sv
// Local-port eject sink: accepts flits, checks destination header,
// buffers for drain, imposes LFSR-driven hold backpressure, keeps stats.
// Ports: flit_in/valid_in/ready_out (router side), drain_* (downstream),
// stall_en_i/stall_thresh_i/hold_len_i (stall control), *_o statistics.
module router_local_eject_sink
   import router_stress_pkg::*;
#(
   parameter int          FLIT_W     = 64,
   parameter int          MY_ROW     = 0,
   parameter int          MY_COL     = 0,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [FLIT_W-1:0]               flit_in,
   input  logic                            valid_in,
   output logic                            ready_out,
   output logic [FLIT_W-1:0]               drain_flit_o,
   output logic                            drain_valid_o,
   input  logic                            drain_ready_i,
   input  logic                            stall_en_i,
   input  logic [7:0]                      stall_thresh_i,
   input  logic [7:0]                      hold_len_i,
   output logic [31:0]                     rx_count_o,
   output logic [15:0]                     misroute_count_o,
   output logic                            misroute_o,
   output logic [15:0]                     max_stall_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_occ_o
);

   eject_state_e state;
   eject_state_e state_nx;
   logic [7:0]   hold_cnt;
   logic [7:0]   hold_cnt_nx;
   logic [15:0]  lfsr;
   logic [15:0]  run_len;
   logic [15:0]  run_inc;
   logic         fifo_full;
   logic         fifo_empty;
   logic         xfer;
   logic         stall_cyc;
   logic         hdr_bad;
   logic         trig;

   eject_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (xfer),
      .din   (flit_in),
      .pop   (drain_ready_i),
      .dout  (drain_flit_o),
      .full  (fifo_full),
      .empty (fifo_empty),
      .occ   (fifo_occ_o)
   );

   // Registered terms only: no path from valid_in or drain_ready_i.
   assign ready_out     = (state == ACCEPT) && !fifo_full;
   assign drain_valid_o = !fifo_empty;
   assign xfer          = valid_in && ready_out;
   assign stall_cyc     = valid_in && !ready_out;

   assign hdr_bad =
      (flit_in[DEST_ROW_MSB:DEST_ROW_LSB] != 8'(MY_ROW)) ||
      (flit_in[DEST_COL_MSB:DEST_COL_LSB] != 8'(MY_COL));

   assign trig = stall_en_i &&
                 (lfsr[7:0] < stall_thresh_i) &&
                 (hold_len_i != 8'd0);

   assign run_inc = (run_len == 16'hFFFF) ? run_len : run_len + 16'd1;

   always_comb begin
      state_nx    = state;
      hold_cnt_nx = hold_cnt;
      unique case (state)
         ACCEPT: begin
            if (trig) begin
               state_nx    = HOLD;
               hold_cnt_nx = hold_len_i;
            end
         end
         HOLD: begin
            // Leaving on count==1 gives exactly hold_len_i low cycles.
            hold_cnt_nx = hold_cnt - 8'd1;
            if (hold_cnt == 8'd1) begin
               state_nx = ACCEPT;
            end
         end
         default: begin
            state_nx    = ACCEPT;
            hold_cnt_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ACCEPT;
         hold_cnt <= '0;
         lfsr     <= LFSR_SEED;
      end else begin
         state    <= state_nx;
         hold_cnt <= hold_cnt_nx;
         lfsr     <= lfsr_next(lfsr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_count_o       <= '0;
         misroute_count_o <= '0;
         misroute_o       <= 1'b0;
      end else if (xfer) begin
         rx_count_o <= rx_count_o + 32'd1;
         if (hdr_bad) begin
            misroute_o <= 1'b1;
            if (misroute_count_o != 16'hFFFF) begin
               misroute_count_o <= misroute_count_o + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_len     <= '0;
         max_stall_o <= '0;
      end else if (stall_cyc) begin
         run_len <= run_inc;
         if (run_inc > max_stall_o) begin
            max_stall_o <= run_inc;
         end
      end else begin
         run_len <= '0;
      end
   end

endmodule

// File: doc/router_local_eject_sink.md
# router_local_eject_sink

Hardware consumer for one tile's router local output port (port index 4). It accepts flits under valid/ready, and can impose LFSR-driven long-tail backpressure on the mesh. Each flit's destination header is checked against the tile's own coordinates, and accepted flits are buffered for a downstream drain interface. It is the receive-side counterpart to local-port injection: instantiated once per tile, it closes the loop for on-chip mesh stress and soak runs without testbench sinks.

## Interface
- FLIT_W, 64, flit width; header in bits [15:0].
- MY_ROW, 0, this tile's row, compared to flit [15:8].
- MY_COL, 0, this tile's column, compared to flit [7:0].
- FIFO_DEPTH, 4, eject buffer depth (power of two, ≥2).
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero).

- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- flit_in  in  FLIT_W  flit from router local output
- valid_in  in  1  flit_in valid
- ready_out  out  1  sink ready; drives router local ready_in
- drain_flit_o  out  FLIT_W  head of eject FIFO
- drain_valid_o  out  1  FIFO non-empty
- drain_ready_i  in  1  downstream pops head
- stall_en_i  in  1  enable random backpressure
- stall_thresh_i  in  8  stall trigger when lfsr[7:0] < thresh
- hold_len_i  in  8  backpressure hold length in cycles
- rx_count_o  out  32  accepted flits, wraps
- misroute_count_o  out  16  header mismatches, saturating
- misroute_o  out  1  sticky mismatch flag
- max_stall_o  out  16  longest run of valid_in && !ready_out, saturating
- fifo_occ_o  out  $clog2(FIFO_DEPTH+1)  current occupancy

## Operation
- Transfer occurs on a cycle with valid_in && ready_out. The flit is pushed to the FIFO, rx_count_o increments, and the header is checked.
- Header mismatch (flit[15:8]!=MY_ROW or flit[7:0]!=MY_COL): misroute_count_o increments (holds at 16'hFFFF) and misroute_o sets until reset. The flit is still stored.
- ready_out = (state==ACCEPT) && (occ < FIFO_DEPTH). There is no bypass: when the FIFO is full, a same-cycle pop does not raise ready_out.
- FSM states are ACCEPT and HOLD.
  - ACCEPT→HOLD when stall_en_i && lfsr[7:0] < stall_thresh_i && hold_len_i != 0. The hold counter loads hold_len_i.
  - In HOLD the counter decrements every cycle. HOLD→ACCEPT on the cycle the counter equals 1, so ready_out is low for exactly hold_len_i cycles.
  - Deasserting stall_en_i during HOLD does not abort the hold.
- LFSR: 16-bit Galois, poly 0xB400, shifts every cycle regardless of state.
- Stall tracking: a run counter increments each cycle with valid_in && !ready_out and clears otherwise. max_stall_o = max(max_stall_o, run+1) on counting cycles, saturating.
- Drain: drain_valid_o = occ!=0. A pop occurs on drain_valid_o && drain_ready_i. A pop on empty is ignored. Simultaneous push and pop leaves occ unchanged.

## Timing
- Reset values:
  - state=ACCEPT, lfsr=LFSR_SEED, FIFO empty.
  - All counters 0, misroute_o=0.
  - drain_valid_o=0, drain_flit_o=0, fifo_occ_o=0.
  - ready_out=1 (combinational from reset state).
- Latency: a flit accepted at edge N appears on drain_flit_o with drain_valid_o after edge N. All stats update at the same edge.
- ready_out depends only on registered state, never combinationally on valid_in or drain_ready_i.
- Reset mid-HOLD or mid-drain returns to reset values immediately. Buffered flits are discarded.
- rx_count_o wraps 32'hFFFFFFFF→0.

## Structure
- Shared package router_stress_pkg:
  - header field positions (DEST_ROW_MSB/LSB, DEST_COL_MSB/LSB)
  - LFSR_POLY = 16'hB400
  - enum eject_state_e {ACCEPT, HOLD}
- One sub-module eject_fifo: synchronous FIFO with push/pop/full/empty/occ, parameterised by width and depth.
- The top level contains the FSM, LFSR, header check and statistics.

## Test plan
- Reset, stall_en_i=0, MY_ROW=1, MY_COL=0, drain_ready_i=1. Inject 10 flits with header 16'h0100 → ready_out stays 1, rx_count_o=10, misroute_count_o=0, each flit appears on drain one cycle after acceptance.
- drain_ready_i=0, inject 6 flits → ready_out drops after the 4th (fifo_occ_o=4) and max_stall_o counts valid-stall cycles. Raising drain_ready_i for one cycle → ready_out returns the following cycle.
- Inject header 16'h0001 at MY_ROW=1, MY_COL=0 → misroute_count_o=1, misroute_o=1. The flit is still drained. misroute_o stays 1 after later correct flits.
- stall_en_i=1, stall_thresh_i=8'hFF, hold_len_i=100, valid_in held → ready_out low exactly 100 cycles per hold, and max_stall_o≥100. hold_len_i=0 → ready_out never drops.
- Assert rst_n=0 during HOLD with 3 flits buffered → ready_out=1, drain_valid_o=0, all counters 0 immediately, LFSR back to 16'hACE1.
- Simultaneous push and pop at occ=2 for 20 cycles → occ stays 2, and output order equals input order.
